// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD up/down counter.
// Provides BCD digit limits, a digit-validity check and width helpers.
package bcd_pkg;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   function automatic logic is_valid_bcd(input logic [3:0] nibble);
      return nibble <= BCD_MAX;
   endfunction

   // Ceiling log2 for elaboration-time sizing.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Prescaler needs at least one bit even when TICK_DIV is 1.
   function automatic int presc_width(input int div);
      int w;
      w = clog2(div);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: holds a 0..9 digit with clear, load and up/down step.
// Ports: clk_i, rst_ni, step_i, up_dn_i, load_i, load_nibble_i, clr_i -> digit_o, at_max_o, at_min_o.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       step_i,
   input  logic       up_dn_i,
   input  logic       load_i,
   input  logic [3:0] load_nibble_i,
   input  logic       clr_i,
   output logic [3:0] digit_o,
   output logic       at_max_o,
   output logic       at_min_o
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;

   assign at_max_o = (digit_q == BCD_MAX);
   assign at_min_o = (digit_q == BCD_MIN);
   assign digit_o  = digit_q;

   // clr and load may both be high, so this is a priority chain.
   always_comb begin
      digit_d = digit_q;
      priority case (1'b1)
         clr_i: digit_d = BCD_MIN;
         load_i: begin
            digit_d = is_valid_bcd(load_nibble_i) ? load_nibble_i : BCD_MIN;
         end
         step_i: begin
            if (up_dn_i)
               digit_d = at_max_o ? BCD_MIN : digit_q + 4'd1;
            else
               digit_d = at_min_o ? BCD_MAX : digit_q - 4'd1;
         end
         default: digit_d = digit_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) digit_q <= BCD_MIN;
      else         digit_q <= digit_d;
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clock-enable prescaler, load, clear, wrap and tc.
// Ports: clk, rst(n), en, up_dn, clr, load, load_val -> bcd_out, tick, wrap, tc.
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 8388608
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  tick,
   output logic                  wrap,
   output logic                  tc
);

   localparam int PW = presc_width(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0]   presc_q;
   logic [PW-1:0]   presc_d;
   logic            tick_q;
   logic            tick_d;
   logic            wrap_q;
   logic            wrap_d;
   logic            roll;
   logic            step;
   logic [DIGITS-1:0] at_max;
   logic [DIGITS-1:0] at_min;
   logic [DIGITS-1:0] dig_step;
   logic [DIGITS:0]   carry;
   logic [DIGITS:0]   borrow;

   assign roll = en & (presc_q == PRESC_LAST);
   // A step coinciding with clr or load is dropped.
   assign step = roll & ~clr & ~load;

   // carry[i]/borrow[i]: every digit below i is at 9 / at 0.
   assign carry[0]  = 1'b1;
   assign borrow[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      assign carry[i+1]  = carry[i] & at_max[i];
      assign borrow[i+1] = borrow[i] & at_min[i];
      assign dig_step[i] = step & (up_dn ? carry[i] : borrow[i]);

      bcd_digit u_digit (
         .clk_i         (clk),
         .rst_ni        (rst),
         .step_i        (dig_step[i]),
         .up_dn_i       (up_dn),
         .load_i        (load),
         .load_nibble_i (load_val[4*i +: 4]),
         .clr_i         (clr),
         .digit_o       (bcd_out[4*i +: 4]),
         .at_max_o      (at_max[i]),
         .at_min_o      (at_min[i])
      );
   end

   assign tc = up_dn ? carry[DIGITS] : borrow[DIGITS];

   always_comb begin
      presc_d = presc_q;
      if (clr || load)
         presc_d = '0;
      else if (en)
         presc_d = roll ? '0 : presc_q + PW'(1);
      tick_d = step;
      wrap_d = step & tc;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   assign tick = tick_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter (DIGITS=2, TICK_DIV=4 and TICK_DIV=1).
// Both instances share stimulus; a monitor compares queued expectations each negedge.
module tb_bcd_updown_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       up_dn;
   logic       clr;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] bcd0, bcd1;
   logic       tick0, tick1, wrap0, wrap1, tc0, tc1;

   int n_cmp;
   int n_bad;

   typedef struct {
      string      nm;
      bit         which;
      logic [7:0] bcd;
      logic       tick;
      logic       wrap;
      logic       tc;
      bit         tick_x;
   } exp_t;

   exp_t q[$];

   int v0, p0, v1, p1;
   bit t0, w0, t1, w1;
   bit mask_tick;

   bcd_updown_counter #(.DIGITS(2), .TICK_DIV(4)) u_dut0 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
      .load(load), .load_val(load_val), .bcd_out(bcd0),
      .tick(tick0), .wrap(wrap0), .tc(tc0)
   );

   bcd_updown_counter #(.DIGITS(2), .TICK_DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
      .load(load), .load_val(load_val), .bcd_out(bcd1),
      .tick(tick1), .wrap(wrap1), .tc(tc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] h, l;
      h = 4'(v / 10);
      l = 4'(v % 10);
      return {h, l};
   endfunction

   function automatic int ld2int(input logic [7:0] lv);
      int h, l;
      h = (lv[7:4] > 4'd9) ? 0 : int'(lv[7:4]);
      l = (lv[3:0] > 4'd9) ? 0 : int'(lv[3:0]);
      return h * 10 + l;
   endfunction

   // Decimal-integer reference model of one edge.
   task automatic mdl(inout int v, inout int p, inout bit t, inout bit w, input int div);
      t = 0;
      w = 0;
      if (clr) begin
         v = 0; p = 0;
      end else if (load) begin
         v = ld2int(load_val); p = 0;
      end else if (en) begin
         if (p == div - 1) begin
            p = 0;
            t = 1;
            if (up_dn) begin
               if (v == 99) begin v = 0; w = 1; end
               else v = v + 1;
            end else begin
               if (v == 0) begin v = 99; w = 1; end
               else v = v - 1;
            end
         end else begin
            p = p + 1;
         end
      end
   endtask

   function automatic logic mtc(input int v);
      return up_dn ? (v == 99) : (v == 0);
   endfunction

   task automatic edge_chk(input string nm);
      exp_t e;
      @(posedge clk);
      mdl(v0, p0, t0, w0, 4);
      mdl(v1, p1, t1, w1, 1);
      #1;
      e = '{nm, 1'b0, to_bcd(v0), t0, w0, mtc(v0), mask_tick};
      q.push_back(e);
      e = '{nm, 1'b1, to_bcd(v1), t1, w1, mtc(v1), mask_tick};
      q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         if (e.which) begin
            chk({e.nm, "_d1_bcd"}, bcd1, e.bcd);
            if (!e.tick_x) chk({e.nm, "_d1_tick"}, 8'(tick1), 8'(e.tick));
            chk({e.nm, "_d1_wrap"}, 8'(wrap1), 8'(e.wrap));
            chk({e.nm, "_d1_tc"}, 8'(tc1), 8'(e.tc));
         end else begin
            chk({e.nm, "_d0_bcd"}, bcd0, e.bcd);
            if (!e.tick_x) chk({e.nm, "_d0_tick"}, 8'(tick0), 8'(e.tick));
            chk({e.nm, "_d0_wrap"}, 8'(wrap0), 8'(e.wrap));
            chk({e.nm, "_d0_tc"}, 8'(tc0), 8'(e.tc));
         end
      end
   end

   initial begin
      n_cmp = 0; n_bad = 0;
      v0 = 0; p0 = 0; v1 = 0; p1 = 0;
      t0 = 0; w0 = 0; t1 = 0; w1 = 0;
      mask_tick = 0;
      rst = 1'b0; en = 1'b0; up_dn = 1'b1;
      clr = 1'b0; load = 1'b0; load_val = 8'h00;
      #1;
      chk("rst_bcd", bcd0, 8'h00);
      chk("rst_tick", 8'(tick0), 8'h00);
      chk("rst_wrap", 8'(wrap0), 8'h00);
      @(negedge clk); #1;
      rst = 1'b1;

      // Count up from 00 over 40 enabled edges.
      en = 1'b1; up_dn = 1'b1;
      repeat (40) edge_chk("t2");
      chk("t2_end", bcd0, 8'h10);

      // Load 98, count up through 99 to wrap.
      en = 1'b0; load = 1'b1; load_val = 8'h98;
      edge_chk("t3_ld");
      load = 1'b0; en = 1'b1;
      repeat (4) edge_chk("t3_up");
      chk("t3_99", bcd0, 8'h99);
      chk("t3_tc", 8'(tc0), 8'h01);
      repeat (4) edge_chk("t3_up");
      chk("t3_00", bcd0, 8'h00);
      chk("t3_wrap", 8'(wrap0), 8'h01);
      edge_chk("t3_after");
      chk("t3_wrap_off", 8'(wrap0), 8'h00);

      // Load 01, count down through 00 to wrap.
      en = 1'b0; up_dn = 1'b0; load = 1'b1; load_val = 8'h01;
      edge_chk("t4_ld");
      load = 1'b0; en = 1'b1;
      repeat (4) edge_chk("t4_dn");
      chk("t4_00", bcd0, 8'h00);
      chk("t4_tc", 8'(tc0), 8'h01);
      repeat (4) edge_chk("t4_dn");
      chk("t4_99", bcd0, 8'h99);
      chk("t4_wrap", 8'(wrap0), 8'h01);
      repeat (8) edge_chk("t4_dn");
      chk("t4_97", bcd0, 8'h97);

      // clr + load coincident with the step edge.
      clr = 1'b1; en = 1'b0;
      edge_chk("t5_pre");
      clr = 1'b0; en = 1'b1; up_dn = 1'b1;
      load_val = 8'h42;
      repeat (3) edge_chk("t5_run");
      clr = 1'b1; load = 1'b1; load_val = 8'hAF;
      mask_tick = 1;
      edge_chk("t5_clr");
      mask_tick = 0;
      chk("t5_clr_bcd", bcd0, 8'h00);
      clr = 1'b0; en = 1'b0;
      edge_chk("t5_ldAF");
      chk("t5_ldAF_bcd", bcd0, 8'h00);
      load_val = 8'hA7;
      edge_chk("t5_ldA7");
      chk("t5_ldA7_bcd", bcd0, 8'h07);
      load = 1'b0; en = 1'b1;
      repeat (3) edge_chk("t5_run2");
      chk("t5_hold", bcd0, 8'h07);
      edge_chk("t5_step");
      chk("t5_step_bcd", bcd0, 8'h08);

      // en low for 10 cycles with prescaler at 2.
      clr = 1'b1;
      edge_chk("t6_clr");
      clr = 1'b0;
      repeat (2) edge_chk("t6_run");
      en = 1'b0;
      repeat (10) edge_chk("t6_hold");
      chk("t6_held", bcd0, 8'h00);
      en = 1'b1;
      edge_chk("t6_e1");
      chk("t6_e1_bcd", bcd0, 8'h00);
      edge_chk("t6_e2");
      chk("t6_e2_bcd", bcd0, 8'h01);

      // TICK_DIV=1 instance steps every enabled edge.
      clr = 1'b1;
      edge_chk("t7_clr");
      clr = 1'b0;
      edge_chk("t7_a");
      chk("t7_01", bcd1, 8'h01);
      edge_chk("t7_b");
      chk("t7_02", bcd1, 8'h02);
      chk("t7_tick", 8'(tick1), 8'h01);

      // Async reset mid-count at 37 with tick high.
      en = 1'b0; load = 1'b1; load_val = 8'h36;
      edge_chk("t1_ld");
      load = 1'b0; en = 1'b1;
      repeat (4) edge_chk("t1_run");
      chk("t1_37", bcd0, 8'h37);
      #2;
      rst = 1'b0;
      #1;
      chk("t1_rst_bcd", bcd0, 8'h00);
      chk("t1_rst_tick", 8'(tick0), 8'h00);
      chk("t1_rst_wrap", 8'(wrap0), 8'h00);
      chk("t1_rst_bcd1", bcd1, 8'h00);
      v0 = 0; p0 = 0; v1 = 0; p1 = 0;
      rst = 1'b1;
      repeat (4) edge_chk("t1_after");
      chk("t1_after_bcd", bcd0, 8'h01);

      en = 1'b0;
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised multi-digit synchronous BCD counter with an integrated clock-enable prescaler.
- Generation after the single-digit divided-clock BCD counter. Adds N cascaded decades, up/down mode, synchronous load and clear, and a wrap/terminal-count output for chaining.
- Single clock domain. No derived clocks: the prescaler produces a one-cycle enable, not a clock.
- Sits between board clock and 7-segment/display decode logic.

Parameters:
- DIGITS, 4, number of cascaded BCD decades (1..8).
- TICK_DIV, 8388608, clk cycles per count step (>=1). 1 means count every enabled cycle.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low. Zeroes all state.
- en  input  1  count enable. Gates both prescaler and counting.
- up_dn  input  1  1 = count up, 0 = count down. Sampled on the counting edge.
- clr  input  1  synchronous clear of digits and prescaler.
- load  input  1  synchronous parallel load.
- load_val  input  4*DIGITS  load value, digit 0 in [3:0].
- bcd_out  output  4*DIGITS  current count, digit 0 = least significant, in [3:0].
- tick  output  1  registered one-cycle prescaler pulse.
- wrap  output  1  registered one-cycle pulse when the count wraps.
- tc  output  1  combinational terminal count: all digits 9 when up_dn=1, all digits 0 when up_dn=0.

Behaviour:
- Reset (rst=0, asynchronous): bcd_out=0, tick=0, wrap=0, prescaler=0. Deassertion is synchronised externally.
- Prescaler:
  - Width is max(1, clog2(TICK_DIV)). It increments only while en=1.
  - When it equals TICK_DIV-1 and en=1: next edge sets it to 0 and makes a count step on that same edge.
  - tick is registered high for the cycle following that edge.
  - en=0 freezes the prescaler; it does not clear.
- Latency: en rises with prescaler=0, so the first count step happens on the TICK_DIV-th rising edge with en=1.
- Priority per edge: clr > load > count step > hold.
  - clr: bcd_out=0, prescaler=0, wrap=0. Ignores en.
  - load: each digit takes its load_val nibble. Any nibble >9 is forced to 0. Prescaler=0, wrap=0. Ignores en.
  - Load or clear coincident with a step: the step is discarded.
- Count up:
  - Digit 0 increments.
  - Digit i increments when every lower digit is 9. A digit at 9 that increments becomes 0.
  - All digits 9 goes to all 0 with wrap=1 for one cycle, coincident with the wrapped value.
- Count down:
  - Digit 0 decrements.
  - Digit i decrements when every lower digit is 0. A digit at 0 that decrements becomes 9.
  - All 0 goes to all 9 with wrap=1.
- up_dn change between steps takes effect on the next step. No glitch, no skipped value.
- Digits never leave 0..9 through counting. Illegal digit codes are unreachable after reset or load.
- wrap=0 on every cycle without a wrapping step.

Decomposition:
- Shared package bcd_pkg:
  - BCD_MAX = 4'd9, BCD_MIN = 4'd0.
  - Function is_valid_bcd(nibble).
  - clog2 helper.
- Sub-module bcd_digit (one per decade, generate loop):
  - Inputs: step, up_dn, load, load_nibble, clr.
  - Outputs: digit value, at_max (=9), at_min (=0).
  - Carry/borrow chain is an AND of lower at_max/at_min, built in the top level.
- Prescaler stays inline in the top level.

Test Plan (DIGITS=2, TICK_DIV=4 unless noted):
1. Reset mid-count at bcd_out=8'h37: assert rst low asynchronously. Required: bcd_out=8'h00, tick=0, wrap=0 immediately, before any clk edge.
2. en=1, up_dn=1 from 00 for 40 clk edges. Required: tick every 4th cycle; bcd_out 01,02..09,10 (no A-F nibbles); step 9 gives 8'h09 to 8'h10 carry.
3. load=1, load_val=8'h98, then count up. Required: 99, then 00 with wrap=1 for exactly one cycle; tc=1 while at 99.
4. Load 8'h01 with up_dn=0, count down. Required: 00, then 99 with wrap=1; tc=1 at 00; wrap=0 elsewhere.
5. Simultaneous clr, load and the step edge at prescaler=3. Required: clr wins, bcd_out=00, prescaler restarts; load_val=8'hAF loads 8'h00 (invalid nibbles forced to 0).
6. en toggled low for 10 cycles with prescaler=2. Required: no step, bcd_out held; after en returns, step occurs 2 enabled edges later. Also TICK_DIV=1: step every enabled edge.
